// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared encodings for the memory port arbiter
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;
    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;
endpackage

// File: rtl/mem_arb_select.sv
// mem_arb_select: D-priority grant decision with an I-port starvation guard
module mem_arb_select #(
    parameter int MAX_D_STREAK = 4
) (
    input  logic Clk,
    input  logic Rst,
    input  logic i_en,
    input  logic d_en,
    input  logic grant,
    output logic grant_i,
    output logic grant_d
);
    logic [3:0] streak;
    logic       i_turn;
    assign i_turn  = i_en & (streak == 4'(MAX_D_STREAK));
    assign grant_d = d_en & ~i_turn;
    assign grant_i = i_en & ~grant_d;
    // count D grants that made a waiting I port wait; a D grant with i_en=1 implies streak < max, so it saturates
    always_ff @(posedge Clk) begin
        if (!Rst)
            streak <= '0;
        else if (grant)
            streak <= (grant_d && i_en) ? streak + 4'd1 : '0;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM between the I-fetch and D ports with miss-style stalls
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_data,
    output logic              i_miss,
    input  logic              d_en,
    input  logic              d_rw,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_miss,
    output logic              m_en,
    output logic              m_rw,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack
);
    import mem_port_arbiter_pkg::*;
    arb_state_t state;
    arb_owner_t owner;
    logic       grant_i, grant_d, arb_go;
    assign arb_go = (state == ARB_IDLE) & (i_en | d_en);
    assign i_miss = i_en & ~(state == ARB_RESP && owner == OWN_I);
    assign d_miss = d_en & ~(state == ARB_RESP && owner == OWN_D);
    mem_arb_select #(.MAX_D_STREAK(MAX_D_STREAK)) u_sel (
        .Clk     (Clk),
        .Rst     (Rst),
        .i_en    (i_en),
        .d_en    (d_en),
        .grant   (arb_go),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );
    // grant, hold the memory request until ack, capture read data, then one bubble
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state   <= ARB_IDLE;
            owner   <= OWN_D;
            m_en    <= 1'b0;
            m_rw    <= RW_READ;
            m_addr  <= '0;
            m_wdata <= '0;
            i_data  <= '0;
            d_rdata <= '0;
        end else begin
            case (state)
                ARB_IDLE: if (arb_go) begin
                    owner   <= grant_d ? OWN_D : OWN_I;
                    m_en    <= 1'b1;
                    m_rw    <= grant_d ? d_rw : RW_READ;
                    m_addr  <= grant_d ? d_addr : i_addr;
                    m_wdata <= grant_d ? d_wdata : '0;
                    state   <= ARB_BUSY;
                end
                ARB_BUSY: if (m_ack) begin
                    if (owner == OWN_I && i_en)
                        i_data <= m_rdata;
                    if (owner == OWN_D && d_en && m_rw == RW_READ)
                        d_rdata <= m_rdata;
                    m_en  <= 1'b0;
                    state <= ARB_RESP;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end
endmodule
